// File: rtl/fpu_operand_unpack.sv
// Operand unpack stage: restores the hidden bit, fixes subnormal exponents, classifies
// both operands and presents them one cycle later through a 2-entry skid buffer.
//
// state | meaning
// EMPTY | output register invalid
// HALF  | output register valid, skid register empty
// FULL  | output and skid registers both valid, input stalled
module fpu_operand_unpack #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  localparam int W     = 1 + EXP_W + MANT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              a_sign_o,
  output logic [EXP_W-1:0]  a_exp_o,
  output logic [MANT_W:0]   a_mant_o,
  output logic [2:0]        a_class_o,
  output logic              b_sign_o,
  output logic [EXP_W-1:0]  b_exp_o,
  output logic [MANT_W:0]   b_mant_o,
  output logic [2:0]        b_class_o,
  output logic              num_status_o
);

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
    logic [2:0]        cls;
  } op_t;

  typedef struct packed {
    op_t  a;
    op_t  b;
    logic num;
  } pair_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  function automatic op_t unpack(input logic [W-1:0] x);
    op_t              o;
    logic [EXP_W-1:0] e;
    logic [MANT_W-1:0] f;
    e      = x[W-2 -: EXP_W];
    f      = x[MANT_W-1:0];
    o.sign = x[W-1];
    o.exp  = e;
    o.mant = {1'b1, f};
    o.cls  = CLS_NORM;
    if (e == '0) begin
      o.mant = {1'b0, f};
      if (f == '0) begin
        o.exp = '0;
        o.cls = CLS_ZERO;
      end else begin
        // subnormals share the minimum normal exponent
        o.exp = EXP_W'(1);
        o.cls = CLS_SUB;
      end
    end else if (&e) begin
      if (f == '0)             o.cls = CLS_INF;
      else if (f[MANT_W-1])    o.cls = CLS_QNAN;
      else                     o.cls = CLS_SNAN;
    end
    return o;
  endfunction

  pair_t  in_pair;
  pair_t  out_q, skid_q;
  state_t state_q, state_d;
  logic   ready_q;
  logic   in_xfer, out_xfer;
  logic   load_out, load_skid, out_from_skid;

  always_comb begin
    in_pair.a   = unpack(a_i);
    in_pair.b   = unpack(b_i);
    in_pair.num = ~(&a_i[W-2 -: EXP_W]) & ~(&b_i[W-2 -: EXP_W]);
  end

  assign valid_o  = (state_q != EMPTY);
  assign ready_o  = ready_q;
  assign in_xfer  = valid_i && ready_q;
  assign out_xfer = valid_o && ready_i;

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_out = 1'b1;
          state_d  = HALF;
        end
      end
      HALF: begin
        if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          out_from_skid = 1'b1;
          state_d       = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      if (load_out)           out_q <= in_pair;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= in_pair;
    end
  end

  assign a_sign_o     = out_q.a.sign;
  assign a_exp_o      = out_q.a.exp;
  assign a_mant_o     = out_q.a.mant;
  assign a_class_o    = out_q.a.cls;
  assign b_sign_o     = out_q.b.sign;
  assign b_exp_o      = out_q.b.exp;
  assign b_mant_o     = out_q.b.mant;
  assign b_class_o    = out_q.b.cls;
  assign num_status_o = out_q.num;

endmodule
